wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 31 +++
 rtl/wb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the register-file writeback arbiter:
// register-address width, XLEN and the writeback source-select encoding.
package wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int NREGS  = 1 << REG_AW;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LU   = 2'd2
    } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// long-latency op issues and cleared when its result is written back.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0] pending_nxt;

    // Clear is applied first so a simultaneous set of the same bit wins;
    // x0 is never tracked.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        if (set_en) pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the in-order pipeline and the
// long-latency unit. Define WB_STARVE_GUARD_EN to enable the LU starvation guard.
//
// LU handshake: a result transfers in a cycle where lu_valid and lu_ready are
// both high; lu_valid/lu_rd/lu_wd must stay stable until that cycle, and
// lu_ready never depends on the transfer having already happened.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_wd,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_wd,
    output logic              lu_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              raw_stall,
    output logic              pipe_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wd
);

    src_e              sel;
    logic [REG_AW-1:0] wr_rd;
    logic [XLEN-1:0]   wr_wd;
    logic              lu_xfer;
    logic              rf_lu;
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  byp_mask;
    logic [NREGS-1:0]  pend_eff;
    logic              sb_set;
    logic              sb_clr;

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign pipe_hold = !rst && lu_valid && (starve_cnt == CW'(STARVE_LIMIT));

    // Never exceeds STARVE_LIMIT: at the limit pipe_hold forces the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         starve_cnt <= '0;
        else if (!lu_valid || lu_xfer)   starve_cnt <= '0;
        else                             starve_cnt <= starve_cnt + 1'b1;
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign pipe_hold = 1'b0;
`endif

    assign lu_ready = !rst && lu_valid && (!pipe_we || pipe_hold);
    assign lu_xfer  = lu_valid && lu_ready;

    always_comb begin
        sel   = SRC_NONE;
        wr_rd = '0;
        wr_wd = '0;
        if (pipe_we && !pipe_hold) begin
            sel   = SRC_PIPE;
            wr_rd = pipe_rd;
            wr_wd = pipe_wd;
        end else if (lu_xfer) begin
            sel   = SRC_LU;
            wr_rd = lu_rd;
            wr_wd = lu_wd;
        end
    end

    // x0 writes are accepted from either source but never reach rf_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
            rf_lu <= 1'b0;
        end else begin
            rf_we <= (sel != SRC_NONE) && (wr_rd != '0);
            rf_rd <= wr_rd;
            rf_wd <= wr_wd;
            rf_lu <= (sel == SRC_LU);
        end
    end

    assign sb_set = issue_valid && issue_ready && (issue_rd != '0);
    assign sb_clr = rf_we && rf_lu;

    wb_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (sb_set),
        .set_idx (issue_rd),
        .clr_en  (sb_clr),
        .clr_idx (rf_rd),
        .pending (pending)
    );

    // The LU result being written this cycle reaches readers via the
    // register file's write-through bypass, so it no longer stalls.
    assign byp_mask = sb_clr ? (NREGS'(1) << rf_rd) : '0;
    assign pend_eff = pending & ~byp_mask;

    assign issue_ready = rst || !pending[issue_rd];
    assign raw_stall   = !rst && (((rs1 != '0) && pend_eff[rs1]) ||
                                  ((rs2 != '0) && pend_eff[rs2]) ||
                                  (pipe_we && pend_eff[pipe_rd]));

endmodule
